mem_access_ctrl: RTL and testbench

Request-side controller that sits directly upstream of the data memory (`mem`) and drives its port set: addr, addr2, write_data, MemRead, MemWrite. It accepts load/store requests from the pipeline over a valid/ready handshake and sequences each one as a single memory access. Load data is returned over a valid/ready response channel. After every reset it first zero-fills the memory with a counter-driven sweep.

---
 rtl/mem_ctrl_pkg.sv | 20 ++
 rtl/mem_access_ctrl_if.sv | 41 ++++
 rtl/mem_init_sweep.sv | 23 ++
 rtl/mem_access_ctrl.sv | 98 +++++++++
 tb/tb_mem_access_ctrl.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared types and constants for the memory access controller
package mem_ctrl_pkg;
   localparam int ADDR_W_DEF = 5;
   localparam int DATA_W_DEF = 32;
   localparam int DEPTH_DEF  = 32;

   typedef enum logic [1:0] {
      ST_INIT,
      ST_IDLE,
      ST_ACCESS,
      ST_RESP
   } state_t;

   localparam logic [DATA_W_DEF-1:0] ZERO_FILL = '0;
   localparam logic [DATA_W_DEF-1:0] RSP_RESET = '0;

   function automatic logic is_last(input int unsigned count, input int unsigned depth);
      return count == depth - 1;
   endfunction
endpackage

// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - request/response and memory-port bundle of the controller
interface mem_access_ctrl_if
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [ADDR_W-1:0] req_addr2;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_data;
   logic [DATA_W-1:0] rsp_data2;
   logic [ADDR_W-1:0] mem_addr;
   logic [ADDR_W-1:0] mem_addr2;
   logic [DATA_W-1:0] mem_write_data;
   logic              MemRead;
   logic              MemWrite;
   logic [DATA_W-1:0] mem_read_data;
   logic [DATA_W-1:0] mem_read_data2;
   logic              init_done;

   // master: pipeline plus memory environment; slave: the controller
   modport master (
      output req_valid, req_we, req_addr, req_addr2, req_wdata, rsp_ready,
             mem_read_data, mem_read_data2,
      input  req_ready, rsp_valid, rsp_data, rsp_data2, mem_addr, mem_addr2,
             mem_write_data, MemRead, MemWrite, init_done
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_addr2, req_wdata, rsp_ready,
             mem_read_data, mem_read_data2,
      output req_ready, rsp_valid, rsp_data, rsp_data2, mem_addr, mem_addr2,
             mem_write_data, MemRead, MemWrite, init_done
   );
endinterface

// File: rtl/mem_init_sweep.sv
// rtl/mem_init_sweep.sv - address counter for the post-reset zero-fill sweep
module mem_init_sweep
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DEPTH  = DEPTH_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic [ADDR_W-1:0] count,
   output logic              done
);
   assign done = start && is_last(32'(count), DEPTH);

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (start) begin
         count <= done ? '0 : count + 1'b1;
      end
   end
endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - sequences load/store requests onto the data memory port set
module mem_access_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = DEPTH_DEF
) (
   input logic               clk,
   input logic               rst,
   mem_access_ctrl_if.slave  bus
);
   state_t            state;
   logic              lat_we;
   logic              sweep_run;
   logic              sweep_last;
   logic [ADDR_W-1:0] sweep_addr;

   assign sweep_run = (state == ST_INIT);

   mem_init_sweep #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_sweep (
      .clk   (clk),
      .rst   (rst),
      .start (sweep_run),
      .count (sweep_addr),
      .done  (sweep_last)
   );

   // mem_addr/mem_addr2/mem_write_data double as the latched request, so they
   // only move on an accept or during the sweep.
   always_ff @(posedge clk) begin
      if (rst) begin
         state              <= ST_INIT;
         lat_we             <= 1'b0;
         bus.req_ready      <= 1'b0;
         bus.rsp_valid      <= 1'b0;
         bus.rsp_data       <= DATA_W'(RSP_RESET);
         bus.rsp_data2      <= DATA_W'(RSP_RESET);
         bus.mem_addr       <= '0;
         bus.mem_addr2      <= '0;
         bus.mem_write_data <= '0;
         bus.MemRead        <= 1'b0;
         bus.MemWrite       <= 1'b0;
         bus.init_done      <= 1'b0;
      end else begin
         case (state)
            ST_INIT: begin
               bus.MemWrite       <= 1'b1;
               bus.MemRead        <= 1'b0;
               bus.mem_addr       <= sweep_addr;
               bus.mem_write_data <= DATA_W'(ZERO_FILL);
               if (sweep_last) state <= ST_IDLE;
            end
            ST_IDLE: begin
               bus.MemWrite  <= 1'b0;
               bus.MemRead   <= 1'b0;
               bus.init_done <= 1'b1;
               if (bus.req_valid && bus.req_ready) begin
                  lat_we             <= bus.req_we;
                  bus.mem_addr       <= bus.req_addr;
                  bus.mem_addr2      <= bus.req_addr2;
                  bus.mem_write_data <= bus.req_wdata;
                  bus.MemWrite       <= bus.req_we;
                  bus.MemRead        <= !bus.req_we;
                  bus.req_ready      <= 1'b0;
                  state              <= ST_ACCESS;
               end else begin
                  bus.req_ready <= 1'b1;
               end
            end
            ST_ACCESS: begin
               bus.MemWrite <= 1'b0;
               bus.MemRead  <= 1'b0;
               if (lat_we) begin
                  bus.req_ready <= 1'b1;
                  state         <= ST_IDLE;
               end else begin
                  bus.rsp_data  <= bus.mem_read_data;
                  bus.rsp_data2 <= bus.mem_read_data2;
                  bus.rsp_valid <= 1'b1;
                  state         <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (bus.rsp_ready) begin
                  bus.rsp_valid <= 1'b0;
                  bus.req_ready <= 1'b1;
                  state         <= ST_IDLE;
               end
            end
            default: state <= ST_INIT;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - self-checking bench for mem_access_ctrl
module tb_mem_access_ctrl;
   import mem_ctrl_pkg::*;

   localparam int AW  = 5;
   localparam int DW  = 32;
   localparam int DEP = 32;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   bit   armed  = 1'b0;

   always #5 clk = ~clk;

   mem_access_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   mem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // level-sensitive memory, pre-filled with junk so the zero-fill matters
   logic [DW-1:0] mem_arr [DEP];
   initial for (int i = 0; i < DEP; i++) mem_arr[i] = $urandom;
   always @(posedge clk) if (bus.MemWrite === 1'b1) mem_arr[bus.mem_addr] <= bus.mem_write_data;
   assign bus.mem_read_data  = mem_arr[bus.mem_addr];
   assign bus.mem_read_data2 = mem_arr[bus.mem_addr2];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // timeline model: n counts clean edges since reset, transactions are tracked as events
   int            n;
   logic [DW-1:0] ref_mem [DEP];
   logic          m_rdy, m_rsp, m_rd, m_wr, m_done, m_we;
   logic [AW-1:0] m_addr, m_addr2;
   logic [DW-1:0] m_wd, m_rdata, m_rdata2;

   always @(posedge clk) begin
      if (rst) begin
         n = 0;
         {m_rdy, m_rsp, m_rd, m_wr, m_done, m_we} = '0;
         m_addr = '0; m_addr2 = '0; m_wd = '0; m_rdata = '0; m_rdata2 = '0;
      end else begin
         logic acc;
         n++;
         acc = m_rdy && bus.req_valid;
         if (m_wr) ref_mem[m_addr] = m_wd;
         if (n <= DEP) begin
            m_wr = 1'b1; m_rd = 1'b0; m_addr = AW'(n - 1); m_wd = '0;
         end else begin
            m_done = 1'b1;
            if (m_rd) begin
               m_rsp = 1'b1; m_rdata = ref_mem[m_addr]; m_rdata2 = ref_mem[m_addr2]; m_rd = 1'b0;
            end else if (m_rsp && bus.rsp_ready) begin
               m_rsp = 1'b0; m_rdy = 1'b1;
            end
            if (m_wr) begin m_wr = 1'b0; m_rdy = 1'b1; end
            if (acc) begin
               m_rdy = 1'b0; m_we = bus.req_we;
               m_addr = bus.req_addr; m_addr2 = bus.req_addr2; m_wd = bus.req_wdata;
               m_wr = m_we; m_rd = !m_we;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (armed) begin
         chk("req_ready",      bus.req_ready,      m_rdy);
         chk("rsp_valid",      bus.rsp_valid,      m_rsp);
         chk("rsp_data",       bus.rsp_data,       m_rdata);
         chk("rsp_data2",      bus.rsp_data2,      m_rdata2);
         chk("mem_addr",       bus.mem_addr,       m_addr);
         chk("mem_addr2",      bus.mem_addr2,      m_addr2);
         chk("mem_write_data", bus.mem_write_data, m_wd);
         chk("MemRead",        bus.MemRead,        m_rd);
         chk("MemWrite",       bus.MemWrite,       m_wr);
         chk("init_done",      bus.init_done,      m_done);
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_ready();
      int k = 0;
      while (bus.req_ready !== 1'b1 && k < 60) begin tick(); k++; end
      chk("wait_ready", bus.req_ready, 1);
   endtask

   task automatic wait_init();
      int k = 0;
      while (bus.init_done !== 1'b1 && k < 60) begin tick(); k++; end
      chk("wait_init", bus.init_done, 1);
   endtask

   task automatic do_store(input logic [AW-1:0] a, input logic [DW-1:0] d);
      wait_ready();
      bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = a;
      bus.req_addr2 = AW'($urandom); bus.req_wdata = d;
      tick();
      chk("store_we",   bus.MemWrite, 1);
      chk("store_addr", bus.mem_addr, 32'(a));
      bus.req_valid = 1'b0;
      tick();
      chk("store_pulse", bus.MemWrite, 0);
   endtask

   task automatic do_load(input logic [AW-1:0] a, input logic [AW-1:0] a2, input int stall,
                          output logic [DW-1:0] d1, output logic [DW-1:0] d2);
      int k = 0;
      wait_ready();
      bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = a;
      bus.req_addr2 = a2; bus.req_wdata = $urandom;
      bus.rsp_ready = (stall == 0);
      tick();
      bus.req_valid = 1'b0;
      while (bus.rsp_valid !== 1'b1 && k < 10) begin tick(); k++; end
      chk("load_latency", k, 1);
      d1 = bus.rsp_data;
      d2 = bus.rsp_data2;
      for (int i = 0; i < stall; i++) begin
         chk("stall_valid", bus.rsp_valid, 1);
         chk("stall_data",  bus.rsp_data,  d1);
         tick();
      end
      bus.rsp_ready = 1'b1;
      tick();
      chk("rsp_consumed", bus.rsp_valid, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      logic [DW-1:0] d1, d2;
      rst = 1'b1;
      bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0;
      bus.req_addr2 = '0; bus.req_wdata = '0; bus.rsp_ready = 1'b1;
      tick();
      armed = 1'b1;
      tick();
      chk("rst_ready", bus.req_ready, 0);
      chk("rst_we",    bus.MemWrite,  0);
      rst = 1'b0;

      // zero-fill sweep timing
      tick();
      chk("sweep_first_addr", bus.mem_addr, 0);
      chk("sweep_first_we",   bus.MemWrite, 1);
      repeat (30) tick();
      tick();
      chk("sweep_last_addr", bus.mem_addr,  31);
      chk("sweep_last_done", bus.init_done, 0);
      tick();
      chk("post_sweep_done",  bus.init_done, 1);
      chk("post_sweep_ready", bus.req_ready, 1);
      chk("post_sweep_we",    bus.MemWrite,  0);

      // store then load back
      do_store(5'd6, 32'd6);
      do_load(5'd6, 5'd1, 0, d1, d2);
      chk("load6_data",  d1, 32'd6);
      chk("load6_data2", d2, 32'd0);

      // stalled response, then a following load
      do_load(5'd0, 5'd2, 5, d1, d2);
      chk("stall_load_data", d1, 32'd0);
      do_load(5'd6, 5'd6, 0, d1, d2);
      chk("after_stall_data", d2, 32'd6);

      // back-to-back stores with req_valid held
      wait_ready();
      bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 5'd31;
      bus.req_addr2 = 5'd3; bus.req_wdata = 32'hDEADBEEF;
      tick();
      chk("b2b_first_we",   bus.MemWrite, 1);
      chk("b2b_first_addr", bus.mem_addr, 31);
      bus.req_addr = 5'd0; bus.req_wdata = 32'h12345678;
      tick();
      chk("b2b_gap_we",    bus.MemWrite,  0);
      chk("b2b_gap_ready", bus.req_ready, 1);
      tick();
      chk("b2b_second_we",   bus.MemWrite, 1);
      chk("b2b_second_addr", bus.mem_addr, 0);
      bus.req_valid = 1'b0;
      tick();
      chk("b2b_end_we", bus.MemWrite, 0);
      do_load(5'd31, 5'd0, 0, d1, d2);
      chk("wrap_data",  d1, 32'hDEADBEEF);
      chk("wrap_data2", d2, 32'h12345678);

      // reset in the middle of the sweep
      rst = 1'b1; tick(); rst = 1'b0;
      repeat (18) tick();
      chk("mid_sweep_addr", bus.mem_addr, 17);
      rst = 1'b1; tick();
      chk("mid_rst_we",   bus.MemWrite, 0);
      chk("mid_rst_addr", bus.mem_addr, 0);
      rst = 1'b0; tick();
      chk("restart_addr", bus.mem_addr, 0);
      chk("restart_we",   bus.MemWrite, 1);
      wait_init();

      // reset while a response is pending
      do_store(5'd5, 32'd55);
      wait_ready();
      bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 5'd5; bus.req_addr2 = 5'd6;
      bus.rsp_ready = 1'b0;
      tick();
      bus.req_valid = 1'b0;
      tick();
      chk("pend_valid", bus.rsp_valid, 1);
      chk("pend_data",  bus.rsp_data,  32'd55);
      rst = 1'b1; tick();
      chk("resp_rst_valid", bus.rsp_valid, 0);
      chk("resp_rst_data",  bus.rsp_data,  0);
      rst = 1'b0;
      bus.rsp_ready = 1'b1;
      wait_init();
      for (int i = 0; i < 4; i++) begin
         chk("no_stale_rsp", bus.rsp_valid, 0);
         tick();
      end
      do_load(5'd5, 5'd6, 0, d1, d2);
      chk("refilled_data",  d1, 32'd0);
      chk("refilled_data2", d2, 32'd0);

      repeat (2) tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
